vc_input_buffer: RTL and testbench
==================================

# vc_input_buffer

Per-input-port virtual-channel buffer for the 2D-mesh router: accepts flits tagged with a VC id and a flit label (HEAD/BODY/TAIL/HEADTAIL), stores them in VC_NUM independent FIFOs, and tracks each VC's packet state so the route-compute and switch stages see only well-formed packets. It sits between the upstream link and the router's route/VC/switch allocation logic. It returns one credit per popped flit and flags protocol violations from upstream.

## Interface
- VC_NUM, 4, number of virtual channels; VC_W = $clog2(VC_NUM), minimum 1
- BUFFER_DEPTH, 4, flits per VC FIFO; power of two, at least 2
- DEST_X_W, 3, x-destination field width
- DEST_Y_W, 3, y-destination field width
- PAYLOAD_W, 16, head payload width; DATA_W = DEST_X_W+DEST_Y_W+PAYLOAD_W; FLIT_W = 2+VC_W+DATA_W
- clk  in  1  clock, all state on the rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  in_flit valid this cycle
- in_flit  in  FLIT_W  {label[1:0], vc_id[VC_W-1:0], data[DATA_W-1:0]}; label HEAD=0, BODY=1, TAIL=2, HEADTAIL=3; head data = {x_dest, y_dest, payload}, MSB first
- route_ack  in  VC_NUM  per-VC pulse: route computed for the head at the front
- rd_en  in  1  pop the front flit of VC rd_vc
- rd_vc  in  VC_W  VC selected for out_flit and pop
- out_flit  out  FLIT_W  front flit of rd_vc (combinational mux); 0 if that VC is empty
- vc_route_req  out  VC_NUM  VC in state ROUTING
- vc_active  out  VC_NUM  VC in state ACTIVE and non-empty
- route_x  out  VC_NUM*DEST_X_W  front-flit x_dest per VC, VC0 in LSBs
- route_y  out  VC_NUM*DEST_Y_W  front-flit y_dest per VC, VC0 in LSBs
- credit_valid  out  1  registered credit pulse
- credit_vc  out  VC_W  VC credited
- err_overflow  out  1  sticky: write to a full VC
- err_protocol  out  1  sticky: label inconsistent with the input-side packet state

## Operation
- Each VC has a FIFO (count 0..BUFFER_DEPTH, rd/wr pointers wrap modulo BUFFER_DEPTH) and an input-side bit in_open[v].
- Write check on in_valid for v = vc_id:
  - HEAD when in_open[v]=1: protocol error.
  - BODY or TAIL when in_open[v]=0: protocol error.
  - HEADTAIL when in_open[v]=1: protocol error.
  - Any protocol error: flit dropped, err_protocol set, in_open unchanged.
  - Otherwise the write is accepted only if count<BUFFER_DEPTH, or a legal pop on the same VC occurs in the same cycle. If neither, the flit is dropped, err_overflow is set, and in_open is unchanged.
  - On an accepted write: HEAD sets in_open; TAIL clears it; BODY and HEADTAIL leave it.
- Output-side FSM per VC:
  - IDLE -> ROUTING when the FIFO is non-empty. Given the write checks, the front flit is always HEAD or HEADTAIL.
  - ROUTING -> ACTIVE on route_ack[v]. route_ack in IDLE or ACTIVE is ignored.
  - ACTIVE: a pop with rd_en && rd_vc==v && non-empty is legal. If the popped flit is TAIL or HEADTAIL, go to IDLE.
  - An rd_en to a VC not ACTIVE, or to an empty VC, is ignored: no pop, no credit, no error.
- route_x/route_y are valid only while vc_route_req[v]=1; otherwise they carry don't-care data, and the bench must not check them.
- Errors stay set until reset.

## Timing
- Reset values: all FIFOs empty; all FSMs IDLE; in_open=0; credit_valid=0; credit_vc=0; err_overflow=0; err_protocol=0; out_flit=0.
- Write at edge N: the flit is at the front (if the FIFO was empty) from N+1. vc_route_req rises at N+2, because the FSM registers the non-empty state.
- route_ack at edge M: vc_active=1 from M+1. The first pop is possible at M+1.
- Pop at edge P: credit_valid=1 with credit_vc=v during P+1 only. One pop per cycle means at most one credit per cycle.
- A TAIL popped at P puts the VC in IDLE at P+1. A following head already buffered raises vc_route_req at P+2, giving a one-cycle bubble per packet.
- Simultaneous write and pop on a full VC: both take effect and count stays BUFFER_DEPTH.
- Simultaneous write and pop on a VC with count 1: the new flit becomes the front at the next edge.
- When rst_n is asserted mid-packet, all state clears immediately. Partially received packets are discarded and no credits are issued for them.

## Test plan
- Reset, then HEADTAIL on VC2 with x=3, y=5 -> vc_route_req=0100 two cycles later and route_x slice 2 = 3. Pulse route_ack[2], then rd_en with rd_vc=2 -> credit_valid with credit_vc=2 one cycle after the pop; VC2 returns to IDLE.
- HEAD+BODY+BODY+TAIL on VC1, interleaved with HEAD+TAIL on VC3 -> each VC pops its flits in order. Exactly 4 credits for VC1 and 2 for VC3; no errors.
- Five flits (HEAD plus 4 BODY) to VC0 with DEPTH=4 and no pops -> fifth flit dropped, err_overflow=1, count stays 4. Repeat with a same-cycle pop -> accepted, no error.
- BODY on an idle VC1, then HEAD, then a second HEAD on VC1 -> err_protocol=1; the BODY and the second HEAD are dropped; only the first HEAD is stored.
- rd_en on a VC in ROUTING, and route_ack on an IDLE VC -> no pop, no credit, no state change.
- Assert rst_n low mid-packet on VC0 with 3 flits buffered -> all outputs at reset values immediately. After release, a new HEAD on VC0 is accepted without err_protocol.

Source files
------------

// File: rtl/vc_input_buffer.sv
// Per-input-port virtual-channel buffer: one FIFO per VC, input-side packet framing checks,
// and an output-side IDLE/ROUTING/ACTIVE sequencer per VC with one credit per popped flit.
module vc_input_buffer #(
   parameter int unsigned VC_NUM       = 4,
   parameter int unsigned BUFFER_DEPTH = 4,
   parameter int unsigned DEST_X_W     = 3,
   parameter int unsigned DEST_Y_W     = 3,
   parameter int unsigned PAYLOAD_W    = 16,
   localparam int unsigned VC_W        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
   localparam int unsigned DATA_W      = DEST_X_W + DEST_Y_W + PAYLOAD_W,
   localparam int unsigned FLIT_W      = 2 + VC_W + DATA_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   input  logic [FLIT_W-1:0]            in_flit,
   input  logic [VC_NUM-1:0]            route_ack,
   input  logic                         rd_en,
   input  logic [VC_W-1:0]              rd_vc,
   output logic [FLIT_W-1:0]            out_flit,
   output logic [VC_NUM-1:0]            vc_route_req,
   output logic [VC_NUM-1:0]            vc_active,
   output logic [VC_NUM*DEST_X_W-1:0]   route_x,
   output logic [VC_NUM*DEST_Y_W-1:0]   route_y,
   output logic                         credit_valid,
   output logic [VC_W-1:0]              credit_vc,
   output logic                         err_overflow,
   output logic                         err_protocol
);

   localparam int unsigned PTR_W = $clog2(BUFFER_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [1:0] LblHead     = 2'd0;
   localparam logic [1:0] LblTail     = 2'd2;
   localparam logic [1:0] LblHeadTail = 2'd3;

   typedef enum logic [1:0] {StIdle, StRouting, StActive} vc_state_e;

   logic [FLIT_W-1:0] mem_q [VC_NUM][BUFFER_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q [VC_NUM];
   logic [PTR_W-1:0]  rd_ptr_d [VC_NUM];
   logic [PTR_W-1:0]  wr_ptr_q [VC_NUM];
   logic [PTR_W-1:0]  wr_ptr_d [VC_NUM];
   logic [CNT_W-1:0]  cnt_q [VC_NUM];
   logic [CNT_W-1:0]  cnt_d [VC_NUM];
   vc_state_e         state_q [VC_NUM];
   vc_state_e         state_d [VC_NUM];
   logic [VC_NUM-1:0] in_open_q, in_open_d;
   logic              credit_valid_q, credit_valid_d;
   logic [VC_W-1:0]   credit_vc_q, credit_vc_d;
   logic              err_ovf_q, err_ovf_d;
   logic              err_proto_q, err_proto_d;

   logic [FLIT_W-1:0] front [VC_NUM];
   logic [VC_NUM-1:0] nonempty;
   logic [VC_NUM-1:0] pop;
   logic [VC_NUM-1:0] wr_en;
   logic [1:0]        in_label;
   logic [VC_W-1:0]   in_vc;
   logic              in_vc_ok;
   logic              in_starts;
   logic              proto_bad;

   assign in_label = in_flit[FLIT_W-1 -: 2];
   assign in_vc    = in_flit[DATA_W +: VC_W];
   assign in_vc_ok = int'(in_vc) < int'(VC_NUM);

   always_comb begin
      for (int v = 0; v < VC_NUM; v++) begin
         front[v]    = mem_q[v][rd_ptr_q[v]];
         nonempty[v] = cnt_q[v] != '0;
         pop[v]      = rd_en && (rd_vc == VC_W'(v)) && (state_q[v] == StActive) && nonempty[v];
      end
   end

   // A head-type label is legal only on a closed VC; body/tail only on an open one.
   always_comb begin
      wr_en       = '0;
      in_starts   = (in_label == LblHead) || (in_label == LblHeadTail);
      proto_bad   = 1'b0;
      err_proto_d = err_proto_q;
      err_ovf_d   = err_ovf_q;
      if (in_valid && in_vc_ok) begin
         proto_bad = in_starts ? in_open_q[in_vc] : !in_open_q[in_vc];
         if (proto_bad) begin
            err_proto_d = 1'b1;
         end else if ((cnt_q[in_vc] < CNT_W'(BUFFER_DEPTH)) || pop[in_vc]) begin
            wr_en[in_vc] = 1'b1;
         end else begin
            err_ovf_d = 1'b1;
         end
      end
   end

   always_comb begin
      credit_valid_d = |pop;
      credit_vc_d    = credit_vc_q;
      in_open_d      = in_open_q;
      for (int v = 0; v < VC_NUM; v++) begin
         rd_ptr_d[v] = rd_ptr_q[v];
         wr_ptr_d[v] = wr_ptr_q[v];
         state_d[v]  = state_q[v];
         if (pop[v]) begin
            rd_ptr_d[v] = rd_ptr_q[v] + PTR_W'(1);
            credit_vc_d = VC_W'(v);
         end
         if (wr_en[v]) begin
            wr_ptr_d[v] = wr_ptr_q[v] + PTR_W'(1);
            if (in_label == LblHead) begin
               in_open_d[v] = 1'b1;
            end else if (in_label == LblTail) begin
               in_open_d[v] = 1'b0;
            end
         end
         cnt_d[v] = cnt_q[v] + CNT_W'(wr_en[v]) - CNT_W'(pop[v]);
         case (state_q[v])
            StIdle:    if (nonempty[v]) state_d[v] = StRouting;
            StRouting: if (route_ack[v]) state_d[v] = StActive;
            // TAIL and HEADTAIL share the label MSB.
            StActive:  if (pop[v] && front[v][FLIT_W-1]) state_d[v] = StIdle;
            default:   state_d[v] = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int v = 0; v < VC_NUM; v++) begin
            rd_ptr_q[v] <= '0;
            wr_ptr_q[v] <= '0;
            cnt_q[v]    <= '0;
            state_q[v]  <= StIdle;
         end
         in_open_q      <= '0;
         credit_valid_q <= 1'b0;
         credit_vc_q    <= '0;
         err_ovf_q      <= 1'b0;
         err_proto_q    <= 1'b0;
      end else begin
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         cnt_q          <= cnt_d;
         state_q        <= state_d;
         in_open_q      <= in_open_d;
         credit_valid_q <= credit_valid_d;
         credit_vc_q    <= credit_vc_d;
         err_ovf_q      <= err_ovf_d;
         err_proto_q    <= err_proto_d;
      end
   end

   // Flit storage needs no reset; emptiness is tracked by cnt_q.
   always_ff @(posedge clk) begin
      for (int v = 0; v < VC_NUM; v++) begin
         if (wr_en[v]) mem_q[v][wr_ptr_q[v]] <= in_flit;
      end
   end

   always_comb begin
      out_flit     = '0;
      vc_route_req = '0;
      vc_active    = '0;
      route_x      = '0;
      route_y      = '0;
      if ((int'(rd_vc) < int'(VC_NUM)) && nonempty[rd_vc]) out_flit = front[rd_vc];
      for (int v = 0; v < VC_NUM; v++) begin
         vc_route_req[v] = state_q[v] == StRouting;
         vc_active[v]    = (state_q[v] == StActive) && nonempty[v];
         route_x[v*DEST_X_W +: DEST_X_W] = front[v][DATA_W-1 -: DEST_X_W];
         route_y[v*DEST_Y_W +: DEST_Y_W] = front[v][DATA_W-DEST_X_W-1 -: DEST_Y_W];
      end
   end

   assign credit_valid = credit_valid_q;
   assign credit_vc    = credit_vc_q;
   assign err_overflow = err_ovf_q;
   assign err_protocol = err_proto_q;

endmodule

// File: tb/tb_vc_input_buffer.sv
// Bench for vc_input_buffer: directed packet scenarios followed by random traffic, all checked
// each cycle against a queue-based packet model.
module tb_vc_input_buffer;

   localparam int VC_NUM = 4;
   localparam int DEPTH  = 4;
   localparam int DATA_W = 22;
   localparam int FLIT_W = 26;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic [FLIT_W-1:0] in_flit = '0;
   logic [3:0]        route_ack = '0;
   logic              rd_en = 1'b0;
   logic [1:0]        rd_vc = '0;
   logic [FLIT_W-1:0] out_flit;
   logic [3:0]        vc_route_req, vc_active;
   logic [11:0]       route_x, route_y;
   logic              credit_valid;
   logic [1:0]        credit_vc;
   logic              err_overflow, err_protocol;

   always #5 clk = ~clk;

   vc_input_buffer #(
      .VC_NUM(4), .BUFFER_DEPTH(4), .DEST_X_W(3), .DEST_Y_W(3), .PAYLOAD_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_flit(in_flit),
      .route_ack(route_ack), .rd_en(rd_en), .rd_vc(rd_vc), .out_flit(out_flit),
      .vc_route_req(vc_route_req), .vc_active(vc_active), .route_x(route_x),
      .route_y(route_y), .credit_valid(credit_valid), .credit_vc(credit_vc),
      .err_overflow(err_overflow), .err_protocol(err_protocol)
   );

   int n_vec = 0;
   int n_miss = 0;
   int obs_cred [VC_NUM];

   // Model: per-VC packet queue, input framing bit, output phase (0 idle, 1 routing, 2 active).
   logic [FLIT_W-1:0] mq [VC_NUM][$];
   bit                m_open [VC_NUM];
   int                m_ph [VC_NUM];
   bit                m_cv;
   logic [1:0]        m_cvc;
   bit                m_eo, m_ep;

   function automatic logic [FLIT_W-1:0] mk(input logic [1:0] lbl, input logic [1:0] vc,
                                            input logic [2:0] x, input logic [2:0] y,
                                            input logic [15:0] pay);
      return {lbl, vc, x, y, pay};
   endfunction

   function automatic void model_reset();
      for (int v = 0; v < VC_NUM; v++) begin
         mq[v].delete();
         m_open[v] = 1'b0;
         m_ph[v]   = 0;
      end
      m_cv  = 1'b0;
      m_cvc = '0;
      m_eo  = 1'b0;
      m_ep  = 1'b0;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      logic [FLIT_W-1:0] f;
      logic [3:0]        erq, eact;
      f = '0;
      if (mq[rd_vc].size() > 0) f = mq[rd_vc][0];
      chk("out_flit", 64'(out_flit), 64'(f));
      for (int v = 0; v < VC_NUM; v++) begin
         erq[v]  = m_ph[v] == 1;
         eact[v] = (m_ph[v] == 2) && (mq[v].size() > 0);
      end
      chk("vc_route_req", 64'(vc_route_req), 64'(erq));
      chk("vc_active", 64'(vc_active), 64'(eact));
      chk("credit_valid", 64'(credit_valid), 64'(m_cv));
      if (m_cv) chk("credit_vc", 64'(credit_vc), 64'(m_cvc));
      chk("err_overflow", 64'(err_overflow), 64'(m_eo));
      chk("err_protocol", 64'(err_protocol), 64'(m_ep));
      for (int v = 0; v < VC_NUM; v++) begin
         if (m_ph[v] == 1 && mq[v].size() > 0) begin
            f = mq[v][0];
            chk("route_x", 64'(route_x[v*3 +: 3]), 64'(f[21:19]));
            chk("route_y", 64'(route_y[v*3 +: 3]), 64'(f[18:16]));
         end
      end
      if (credit_valid === 1'b1) obs_cred[credit_vc]++;
   endtask

   task automatic model_edge();
      bit                popped, bad, accept;
      logic [FLIT_W-1:0] pf, wf;
      int                wv, pv;
      int                nph [VC_NUM];
      logic [1:0]        lbl;
      pv     = int'(rd_vc);
      popped = rd_en && m_ph[pv] == 2 && mq[pv].size() > 0;
      pf     = popped ? mq[pv][0] : '0;
      for (int v = 0; v < VC_NUM; v++) begin
         nph[v] = m_ph[v];
         if (m_ph[v] == 0 && mq[v].size() > 0) nph[v] = 1;
         else if (m_ph[v] == 1 && route_ack[v]) nph[v] = 2;
         else if (m_ph[v] == 2 && popped && pv == v &&
                  (pf[FLIT_W-1:FLIT_W-2] == 2'd2 || pf[FLIT_W-1:FLIT_W-2] == 2'd3)) nph[v] = 0;
      end
      accept = 1'b0;
      wf     = in_flit;
      wv     = int'(wf[DATA_W +: 2]);
      lbl    = wf[FLIT_W-1:FLIT_W-2];
      if (in_valid) begin
         case (lbl)
            2'd0:    bad = m_open[wv];
            2'd3:    bad = m_open[wv];
            default: bad = !m_open[wv];
         endcase
         if (bad) m_ep = 1'b1;
         else if (mq[wv].size() < DEPTH || (popped && pv == wv)) accept = 1'b1;
         else m_eo = 1'b1;
      end
      if (popped) void'(mq[pv].pop_front());
      if (accept) begin
         mq[wv].push_back(wf);
         if (lbl == 2'd0) m_open[wv] = 1'b1;
         if (lbl == 2'd2) m_open[wv] = 1'b0;
      end
      m_cv = popped;
      if (popped) m_cvc = rd_vc;
      for (int v = 0; v < VC_NUM; v++) m_ph[v] = nph[v];
   endtask

   task automatic step();
      @(negedge clk);
      check_outputs();
      model_edge();
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      route_ack = '0;
      rd_en     = 1'b0;
   endtask

   task automatic send(input logic [FLIT_W-1:0] f);
      in_valid = 1'b1;
      in_flit  = f;
      step();
   endtask

   task automatic pop_vc(input logic [1:0] v);
      rd_en = 1'b1;
      rd_vc = v;
      step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs();
      chk("credit_vc_rst", 64'(credit_vc), 64'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [1:0] lbl, vc;
      model_reset();
      #1;
      check_outputs();
      chk("credit_vc_rst", 64'(credit_vc), 64'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single HEADTAIL on VC2 with x=3, y=5.
      send(mk(2'd3, 2'd2, 3'd3, 3'd5, 16'hABCD));
      step();
      step();
      chk("vc2_route_req", 64'(vc_route_req), 64'(4'b0100));
      chk("vc2_route_x", 64'(route_x[8:6]), 64'(3));
      route_ack = 4'b0100;
      step();
      pop_vc(2'd2);
      step();
      step();

      // Interleaved packets on VC1 and VC3.
      for (int v = 0; v < VC_NUM; v++) obs_cred[v] = 0;
      send(mk(2'd0, 2'd1, 3'd1, 3'd2, 16'h1111));
      send(mk(2'd0, 2'd3, 3'd6, 3'd7, 16'h3333));
      send(mk(2'd1, 2'd1, 3'd0, 3'd0, 16'h1112));
      send(mk(2'd2, 2'd3, 3'd0, 3'd0, 16'h3334));
      send(mk(2'd1, 2'd1, 3'd0, 3'd0, 16'h1113));
      send(mk(2'd2, 2'd1, 3'd0, 3'd0, 16'h1114));
      step();
      route_ack = 4'b1010;
      step();
      pop_vc(2'd1);
      pop_vc(2'd3);
      pop_vc(2'd1);
      pop_vc(2'd3);
      pop_vc(2'd1);
      pop_vc(2'd1);
      step();
      step();
      chk("vc1_credits", 64'(obs_cred[1]), 64'(4));
      chk("vc3_credits", 64'(obs_cred[3]), 64'(2));

      // Overflow on VC0: fill, then a write with same-cycle pop, then a write without.
      do_reset();
      send(mk(2'd0, 2'd0, 3'd2, 3'd4, 16'h0A00));
      for (int i = 1; i < 4; i++) send(mk(2'd1, 2'd0, 3'd0, 3'd0, 16'(i)));
      step();
      route_ack = 4'b0001;
      step();
      in_valid = 1'b1;
      in_flit  = mk(2'd1, 2'd0, 3'd0, 3'd0, 16'h0004);
      rd_en    = 1'b1;
      rd_vc    = 2'd0;
      step();
      chk("no_ovf_with_pop", 64'(err_overflow), 64'(0));
      send(mk(2'd1, 2'd0, 3'd0, 3'd0, 16'h0005));
      step();
      chk("ovf_sticky", 64'(err_overflow), 64'(1));

      // Protocol errors on VC1, then ignored rd_en/route_ack.
      do_reset();
      rd_vc = 2'd1;
      send(mk(2'd1, 2'd1, 3'd0, 3'd0, 16'hBAD0));
      send(mk(2'd0, 2'd1, 3'd5, 3'd1, 16'h600D));
      send(mk(2'd0, 2'd1, 3'd7, 3'd7, 16'hBAD1));
      step();
      pop_vc(2'd1);
      route_ack = 4'b0100;
      step();
      step();
      chk("proto_sticky", 64'(err_protocol), 64'(1));

      // Reset mid-packet with three flits on VC0.
      do_reset();
      rd_vc = 2'd0;
      send(mk(2'd0, 2'd0, 3'd1, 3'd1, 16'hC000));
      send(mk(2'd1, 2'd0, 3'd0, 3'd0, 16'hC001));
      send(mk(2'd1, 2'd0, 3'd0, 3'd0, 16'hC002));
      step();
      #2;
      do_reset();
      send(mk(2'd0, 2'd0, 3'd4, 3'd3, 16'hD000));
      step();
      step();

      // Random traffic, mostly well-framed.
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         vc = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) lbl = 2'($urandom_range(0, 3));
         else if (m_open[vc]) lbl = 2'($urandom_range(1, 2));
         else lbl = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
         in_valid  = $urandom_range(0, 1) == 1;
         in_flit   = mk(lbl, vc, 3'($urandom), 3'($urandom), 16'($urandom));
         rd_en     = $urandom_range(0, 2) != 0;
         rd_vc     = 2'($urandom_range(0, 3));
         route_ack = 4'($urandom) & 4'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
